jt900h_busarb: RTL and testbench

Bus arbiter and cycle sequencer for the TLCS-900H external 16-bit bus. It shares the physical bus between three requesters: the CPU memory unit, the micro-DMA engine, and an external master using BUSRQ/BUSAK. It inserts programmable and external wait states and guarantees clean ownership hand-offs. It sits between the memory unit and the memory map/chip top.

---
 rtl/jt900h_busarb_pkg.sv | 29 ++
 rtl/jt900h_busarb_if.sv | 20 ++
 rtl/jt900h_busarb_cyc.sv | 63 ++++++
 rtl/jt900h_busarb.sv | 142 ++++++++++++++
 tb/tb_jt900h_busarb.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/jt900h_busarb_pkg.sv
// Shared types for the TLCS-900H bus arbiter: FSM states, owner codes, access record.
package jt900h_busarb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU,
        ST_DMA,
        ST_HAND,
        ST_REL
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } owner_t;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] din;
        logic [1:0]  we;
        logic        rd;
    } acc_t;

    // An access is requested when either a read or any write byte lane is set.
    function automatic logic acc_valid(acc_t a);
        return a.rd | (|a.we);
    endfunction

endpackage

// File: rtl/jt900h_busarb_if.sv
// Physical external bus between the arbiter (master) and the memory map (slave).
interface jt900h_busarb_if;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_we;
    logic        mem_rd;
    logic        mem_oe;
    logic [15:0] mem_dout;
    logic        ext_wait_n;

    modport master (
        output mem_addr, mem_din, mem_we, mem_rd, mem_oe,
        input  mem_dout, ext_wait_n
    );

    modport slave (
        input  mem_addr, mem_din, mem_we, mem_rd, mem_oe,
        output mem_dout, ext_wait_n
    );
endinterface

// File: rtl/jt900h_busarb_cyc.sv
// Access sequencer: latches the owner's access, counts wait states, honours
// ext_wait_n and produces the one-cycle ack plus captured read data.
module jt900h_busarb_cyc
    import jt900h_busarb_pkg::*;
#(
    parameter int unsigned WAITW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             go,
    input  owner_t           own,
    input  acc_t             acc,
    input  logic [WAITW-1:0] waits,
    input  logic             ext_wait_n,
    input  logic [15:0]      mem_dout,
    output acc_t             lat,
    output logic             active,
    output logic             done,
    output logic             cpu_ack,
    output logic             dma_ack,
    output logic [15:0]      rdata
);

    logic [WAITW-1:0] wcnt;
    owner_t           lat_own;

    // ext_wait_n only matters once the programmed waits have run out.
    assign done = cen & active & (wcnt == '0) & ext_wait_n;

    // Start, wait-count, completion and back-to-back relatch of accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat     <= '0;
            wcnt    <= '0;
            active  <= 1'b0;
            lat_own <= OWN_CPU;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            rdata   <= '0;
        end else if (cen) begin
            cpu_ack <= done && (lat_own == OWN_CPU);
            dma_ack <= done && (lat_own == OWN_DMA);
            if (done && lat.rd) rdata <= mem_dout;
            if (go && (!active || done)) begin
                lat.addr <= acc.addr;
                lat.din  <= acc.din;
                lat.we   <= acc.we;
                lat.rd   <= acc.rd & ~|acc.we;  // write wins over read
                wcnt     <= waits;
                active   <= 1'b1;
                lat_own  <= own;
            end else if (done) begin
                lat.we <= '0;
                lat.rd <= 1'b0;
                active <= 1'b0;
            end else if (active && (wcnt != '0)) begin
                wcnt <= wcnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/jt900h_busarb.sv
// TLCS-900H external bus arbiter: ownership FSM (external > DMA > CPU) and
// request mux in front of the access sequencer.
module jt900h_busarb
    import jt900h_busarb_pkg::*;
#(
    parameter int unsigned WAITW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             cpu_req,
    input  logic             cpu_lock,
    input  logic [23:0]      cpu_addr,
    input  logic [15:0]      cpu_din,
    input  logic [1:0]       cpu_we,
    input  logic             cpu_rd,
    output logic             cpu_gnt,
    output logic             cpu_ack,
    input  logic             dma_req,
    input  logic             dma_lock,
    input  logic [23:0]      dma_addr,
    input  logic [15:0]      dma_din,
    input  logic [1:0]       dma_we,
    input  logic             dma_rd,
    output logic             dma_gnt,
    output logic             dma_ack,
    input  logic             busrq_n,
    output logic             busak_n,
    input  logic [WAITW-1:0] waits,
    output logic [15:0]      rdata,
    jt900h_busarb_if.master  mem
);

    state_t state;
    logic   to_rel, dma_block, mem_oe;
    logic   ext_req, dma_ok, acc_req, leave, go, active, done;
    owner_t own;
    acc_t   cpu_acc, dma_acc, sel, lat;

    assign cpu_acc = {cpu_addr, cpu_din, cpu_we, cpu_rd};
    assign dma_acc = {dma_addr, dma_din, dma_we, dma_rd};
    assign ext_req = ~busrq_n;
    // DMA stays blocked only while the CPU still waits for its turn.
    assign dma_ok  = dma_req & ~(dma_block & cpu_req);

    // Request mux and hand-off decision for the current owner.
    always_comb begin
        own     = (state == ST_DMA) ? OWN_DMA : OWN_CPU;
        sel     = (state == ST_DMA) ? dma_acc : cpu_acc;
        acc_req = ((state == ST_CPU) || (state == ST_DMA)) && acc_valid(sel);
        leave   = 1'b0;
        unique case (state)
            ST_CPU:  leave = !active && !cpu_lock && (ext_req || dma_ok || !cpu_req);
            ST_DMA:  leave = !active && !dma_lock && (ext_req || !dma_req);
            default: leave = 1'b0;
        endcase
        go = acc_req && !leave;
    end

    // Ownership FSM with registered grants, busak_n and mem_oe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cpu_gnt   <= 1'b0;
            dma_gnt   <= 1'b0;
            busak_n   <= 1'b1;
            mem_oe    <= 1'b1;
            to_rel    <= 1'b0;
            dma_block <= 1'b0;
        end else if (cen) begin
            if (done && (state == ST_CPU)) dma_block <= 1'b0;
            unique case (state)
                ST_IDLE, ST_HAND: begin
                    if (ext_req || (state == ST_HAND && to_rel)) begin
                        state   <= ST_REL;
                        busak_n <= 1'b0;
                        mem_oe  <= 1'b0;
                        to_rel  <= 1'b0;
                    end else if (dma_ok) begin
                        state   <= ST_DMA;
                        dma_gnt <= 1'b1;
                    end else if (cpu_req) begin
                        state   <= ST_CPU;
                        cpu_gnt <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CPU: begin
                    if (leave) begin
                        state   <= ST_HAND;
                        cpu_gnt <= 1'b0;
                        to_rel  <= ext_req;
                    end
                end
                ST_DMA: begin
                    if (leave) begin
                        state     <= ST_HAND;
                        dma_gnt   <= 1'b0;
                        to_rel    <= ext_req;
                        dma_block <= cpu_req;
                    end
                end
                ST_REL: begin
                    if (busrq_n) begin
                        state   <= ST_HAND;
                        busak_n <= 1'b1;
                        mem_oe  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    jt900h_busarb_cyc #(
        .WAITW (WAITW)
    ) u_cyc (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .go         (go),
        .own        (own),
        .acc        (sel),
        .waits      (waits),
        .ext_wait_n (mem.ext_wait_n),
        .mem_dout   (mem.mem_dout),
        .lat        (lat),
        .active     (active),
        .done       (done),
        .cpu_ack    (cpu_ack),
        .dma_ack    (dma_ack),
        .rdata      (rdata)
    );

    assign mem.mem_addr = lat.addr;
    assign mem.mem_din  = lat.din;
    assign mem.mem_we   = lat.we;
    assign mem.mem_rd   = lat.rd;
    assign mem.mem_oe   = mem_oe;

endmodule

// File: tb/tb_jt900h_busarb.sv
// Directed bench for jt900h_busarb: per-cycle vector table plus hand-written
// sequences for lock, fairness, wait states and asynchronous reset.
module tb_jt900h_busarb;

    logic        clk, rst_n, cen;
    logic        cpu_req, cpu_lock, cpu_rd, cpu_gnt, cpu_ack;
    logic [23:0] cpu_addr, dma_addr;
    logic [15:0] cpu_din, dma_din, rdata;
    logic [1:0]  cpu_we, dma_we, waits;
    logic        dma_req, dma_lock, dma_rd, dma_gnt, dma_ack;
    logic        busrq_n, busak_n;

    int checks = 0;
    int failures = 0;

    jt900h_busarb_if bus ();

    jt900h_busarb #(
        .WAITW (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .cpu_req  (cpu_req),
        .cpu_lock (cpu_lock),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_we   (cpu_we),
        .cpu_rd   (cpu_rd),
        .cpu_gnt  (cpu_gnt),
        .cpu_ack  (cpu_ack),
        .dma_req  (dma_req),
        .dma_lock (dma_lock),
        .dma_addr (dma_addr),
        .dma_din  (dma_din),
        .dma_we   (dma_we),
        .dma_rd   (dma_rd),
        .dma_gnt  (dma_gnt),
        .dma_ack  (dma_ack),
        .busrq_n  (busrq_n),
        .busak_n  (busak_n),
        .waits    (waits),
        .rdata    (rdata),
        .mem      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic       req;
        logic       rd;
        logic       brq_n;
        logic [6:0] exp;  // cpu_gnt dma_gnt cpu_ack dma_ack mem_rd mem_oe busak_n
    } vec_t;

    vec_t tbl [23];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {cpu_gnt, dma_gnt, cpu_ack, dma_ack, bus.mem_rd, bus.mem_oe, busak_n};
    endfunction

    initial begin
        int strobes, acks, bad, rd_seen;

        tbl[0]  = {3'b111, 7'b1000011};  // IDLE -> CPU grant
        tbl[1]  = {3'b111, 7'b1000111};  // access starts
        tbl[2]  = {3'b101, 7'b1010011};  // completes, ack
        tbl[3]  = {3'b101, 7'b1000011};
        tbl[4]  = {3'b001, 7'b0000011};  // CPU -> HAND
        tbl[5]  = {3'b001, 7'b0000011};  // HAND -> IDLE
        tbl[6]  = {3'b111, 7'b1000011};
        tbl[7]  = {3'b111, 7'b1000111};
        tbl[8]  = {3'b100, 7'b1010011};  // busrq during access: finishes
        tbl[9]  = {3'b100, 7'b0000011};  // HAND
        tbl[10] = {3'b100, 7'b0000000};  // REL
        tbl[11] = {3'b100, 7'b0000000};
        tbl[12] = {3'b101, 7'b0000011};  // REL -> HAND
        tbl[13] = {3'b101, 7'b1000011};  // CPU regranted
        tbl[14] = {3'b100, 7'b0000011};  // CPU -> HAND for external
        tbl[15] = {3'b101, 7'b0000000};  // REL still entered
        tbl[16] = {3'b101, 7'b0000011};
        tbl[17] = {3'b101, 7'b1000011};
        tbl[18] = {3'b001, 7'b0000011};
        tbl[19] = {3'b001, 7'b0000011};  // IDLE
        tbl[20] = {3'b000, 7'b0000000};  // IDLE -> REL directly
        tbl[21] = {3'b001, 7'b0000011};
        tbl[22] = {3'b001, 7'b0000011};

        rst_n = 1'b0; cen = 1'b1; waits = 2'd0;
        cpu_req = 1'b0; cpu_lock = 1'b0; cpu_rd = 1'b0; cpu_we = 2'b00;
        cpu_addr = 24'h001234; cpu_din = 16'h0000;
        dma_req = 1'b0; dma_lock = 1'b0; dma_rd = 1'b0; dma_we = 2'b00;
        dma_addr = 24'h200000; dma_din = 16'h55AA;
        busrq_n = 1'b1;
        bus.mem_dout = 16'hBEEF; bus.ext_wait_n = 1'b1;

        #12;
        chk("reset_outs", {25'd0, outs()}, {25'd0, 7'b0000011});
        chk("reset_addr", {8'd0, bus.mem_addr}, 32'd0);
        chk("reset_din_we", {14'd0, bus.mem_din, bus.mem_we}, 32'd0);
        chk("reset_rdata", {16'd0, rdata}, 32'd0);
        rst_n = 1'b1;

        // cen low freezes the FSM
        cen = 1'b0; cpu_req = 1'b1;
        tick();
        chk("cen_hold", {31'd0, cpu_gnt}, 32'd0);
        cen = 1'b1;

        for (int i = 0; i < 23; i++) begin
            cpu_req = tbl[i].req; cpu_rd = tbl[i].rd; busrq_n = tbl[i].brq_n;
            tick();
            chk($sformatf("vec%0d", i), {25'd0, outs()}, {25'd0, tbl[i].exp});
            if (i == 2) begin
                chk("rdata_beef", {16'd0, rdata}, 32'h0000BEEF);
                chk("cpu_addr", {8'd0, bus.mem_addr}, 32'h00001234);
            end
        end

        // CPU lock across two accesses while DMA requests
        cpu_req = 1'b1; cpu_lock = 1'b1; cpu_rd = 1'b1;
        tick(); chk("lock_gnt", {31'd0, cpu_gnt}, 32'd1);
        tick(); chk("lock_rd1", {31'd0, bus.mem_rd}, 32'd1);
        dma_req = 1'b1; cpu_rd = 1'b0;
        tick(); chk("lock_ack1", {30'd0, cpu_ack, dma_gnt}, 32'd2);
        cpu_rd = 1'b1;
        tick(); chk("lock_rd2", {29'd0, cpu_gnt, dma_gnt, bus.mem_rd}, 32'd5);
        cpu_rd = 1'b0;
        tick(); chk("lock_ack2", {31'd0, cpu_ack}, 32'd1);
        cpu_lock = 1'b0;
        tick(); chk("lock_hand", {27'd0, cpu_gnt, dma_gnt, bus.mem_rd, bus.mem_we}, 32'd0);
        tick(); chk("lock_dma_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'd1);

        // Fairness: CPU gets exactly one access before DMA returns
        dma_req = 1'b0;
        tick(); chk("fair_hand", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
        dma_req = 1'b1;
        tick(); chk("fair_cpu", {30'd0, cpu_gnt, dma_gnt}, 32'd2);
        cpu_rd = 1'b1;
        tick(); chk("fair_rd", {31'd0, bus.mem_rd}, 32'd1);
        cpu_rd = 1'b0;
        tick(); chk("fair_ack", {31'd0, cpu_ack}, 32'd1);
        cpu_rd = 1'b1;
        tick(); chk("fair_one", {29'd0, cpu_gnt, dma_gnt, bus.mem_rd}, 32'd0);
        tick(); chk("fair_dma", {30'd0, cpu_gnt, dma_gnt}, 32'd1);
        cpu_rd = 1'b0; cpu_req = 1'b0;

        // DMA write, waits=2, ext_wait_n low for three sampled cycles; rd also set
        waits = 2'd2; dma_we = 2'b11; dma_rd = 1'b1;
        tick();
        dma_we = 2'b00; dma_rd = 1'b0;
        strobes = (bus.mem_we == 2'b11) ? 1 : 0;
        rd_seen = bus.mem_rd ? 1 : 0;
        acks = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus.ext_wait_n = (i < 5) ? 1'b0 : 1'b1;
            tick();
            if (bus.mem_we == 2'b11) begin
                strobes++;
                if (bus.mem_din != 16'h55AA) bad++;
            end
            if (bus.mem_rd) rd_seen++;
            if (dma_ack) acks++;
        end
        chk("dma_strobes", strobes, 6);
        chk("dma_acks", acks, 1);
        chk("dma_din_bad", bad, 0);
        chk("dma_rd_ignored", rd_seen, 0);
        chk("dma_addr", {8'd0, bus.mem_addr}, 32'h00200000);
        dma_req = 1'b0;
        tick(); tick();

        // Asynchronous reset mid-access with wcnt=1
        waits = 2'd1; cpu_req = 1'b1; cpu_rd = 1'b1;
        tick(); tick();
        chk("rst_pre_rd", {31'd0, bus.mem_rd}, 32'd1);
        cpu_rd = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("rst_drop", {28'd0, bus.mem_rd, bus.mem_we, cpu_gnt}, 32'd0);
        cpu_req = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        acks = (cpu_ack || dma_ack) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cpu_ack || dma_ack) acks++;
        end
        chk("rst_no_ack", acks, 0);
        chk("rst_idle_outs", {25'd0, outs()}, {25'd0, 7'b0000011});
        cpu_req = 1'b1;
        tick(); chk("rst_regrant", {31'd0, cpu_gnt}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
